// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding and
// the widths used by the byte assembler.
package ifetch_ctrl_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int ICacheIndexSize = 64;
  localparam int BYTE_CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    FILL = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Bundle of queue, ICache and memory-arbiter signals around ifetch_ctrl.
// The master side is the controller; the slave side is its environment.
interface ifetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              rdy;
  logic              fetch_req;
  logic [ADDR_W-1:0] pc_in;
  logic              queue_full;
  logic              flush;

  logic [ADDR_W-1:0] icache_addr;
  logic              icache_hit;
  logic [INST_W-1:0] icache_inst;
  logic              icache_we;
  logic [ADDR_W-1:0] icache_waddr;
  logic [INST_W-1:0] icache_wdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_grant;
  logic              mem_byte_valid;
  logic [7:0]        mem_byte;

  logic              inst_valid;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    input  rdy, fetch_req, pc_in, queue_full, flush,
    input  icache_hit, icache_inst,
    input  mem_grant, mem_byte_valid, mem_byte,
    output icache_addr, icache_we, icache_waddr, icache_wdata,
    output mem_req, mem_addr,
    output inst_valid, inst_out, inst_pc
  );

  modport slave (
    output rdy, fetch_req, pc_in, queue_full, flush,
    output icache_hit, icache_inst,
    output mem_grant, mem_byte_valid, mem_byte,
    input  icache_addr, icache_we, icache_waddr, icache_wdata,
    input  mem_req, mem_addr,
    input  inst_valid, inst_out, inst_pc
  );

endinterface

// File: rtl/ifetch_byte_asm.sv
// Little-endian assembly of four serial bytes into one instruction word.
// word_o already includes a byte captured this cycle so the caller can latch it on done_o.
module ifetch_byte_asm
  import ifetch_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  done_o
);

  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (en_i) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_i;
      cnt_d                        = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_d;
  assign done_o = en_i && !clr_i && (&cnt_q);

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: ICache lookup, byte-serial miss refill,
// flush/abandon handling and global rdy stall.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_ctrl_if.master bus
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] missPc_q, missPc_d;
  logic              abandon_q, abandon_d;
  logic              instValid_q, instValid_d;
  logic [INST_W-1:0] instOut_q, instOut_d;
  logic [ADDR_W-1:0] instPc_q, instPc_d;
  logic              icacheWe_q, icacheWe_d;
  logic [ADDR_W-1:0] icacheWaddr_q, icacheWaddr_d;
  logic [INST_W-1:0] icacheWdata_q, icacheWdata_d;
  logic              memReq_q, memReq_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;

  logic                  accept;
  logic                  asmClr, asmEn;
  logic                  asmDone;
  logic [DATA_WIDTH-1:0] asmWord;

  ifetch_byte_asm u_byte_asm (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (asmClr && bus.rdy),
    .en_i   (asmEn && bus.rdy),
    .byte_i (bus.mem_byte),
    .word_o (asmWord),
    .done_o (asmDone)
  );

  assign accept = (state_q == IDLE) && bus.fetch_req && !bus.queue_full &&
                  !bus.flush && !instValid_q;

  // Once a transfer is granted it cannot be cancelled, so a flush only marks
  // it abandoned; the refill still happens but delivery is suppressed.
  always_comb begin
    state_d       = state_q;
    missPc_d      = missPc_q;
    abandon_d     = abandon_q;
    instValid_d   = 1'b0;
    instOut_d     = instOut_q;
    instPc_d      = instPc_q;
    icacheWe_d    = 1'b0;
    icacheWaddr_d = icacheWaddr_q;
    icacheWdata_d = icacheWdata_q;
    memReq_d      = memReq_q;
    memAddr_d     = memAddr_q;
    asmClr        = 1'b0;
    asmEn         = 1'b0;

    case (state_q)
      IDLE: begin
        abandon_d = 1'b0;
        if (accept) begin
          if (bus.icache_hit) begin
            instValid_d = 1'b1;
            instOut_d   = bus.icache_inst;
            instPc_d    = bus.pc_in;
          end else begin
            missPc_d  = bus.pc_in;
            memReq_d  = 1'b1;
            memAddr_d = bus.pc_in;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        if (bus.mem_grant) begin
          memReq_d  = 1'b0;
          asmClr    = 1'b1;
          abandon_d = bus.flush;
          state_d   = RECV;
        end else if (bus.flush) begin
          memReq_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RECV: begin
        asmEn = bus.mem_byte_valid;
        if (bus.flush) begin
          abandon_d = 1'b1;
        end
        if (asmDone) begin
          icacheWe_d    = 1'b1;
          icacheWaddr_d = missPc_q;
          icacheWdata_d = asmWord;
          state_d       = FILL;
          if (!abandon_q && !bus.flush) begin
            instValid_d = 1'b1;
            instOut_d   = asmWord;
            instPc_d    = missPc_q;
          end
        end
      end
      FILL: begin
        abandon_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      missPc_q      <= '0;
      abandon_q     <= 1'b0;
      instValid_q   <= 1'b0;
      instOut_q     <= '0;
      instPc_q      <= '0;
      icacheWe_q    <= 1'b0;
      icacheWaddr_q <= '0;
      icacheWdata_q <= '0;
      memReq_q      <= 1'b0;
      memAddr_q     <= '0;
    end else if (bus.rdy) begin
      state_q       <= state_d;
      missPc_q      <= missPc_d;
      abandon_q     <= abandon_d;
      instValid_q   <= instValid_d;
      instOut_q     <= instOut_d;
      instPc_q      <= instPc_d;
      icacheWe_q    <= icacheWe_d;
      icacheWaddr_q <= icacheWaddr_d;
      icacheWdata_q <= icacheWdata_d;
      memReq_q      <= memReq_d;
      memAddr_q     <= memAddr_d;
    end
  end

  // A stalled pipeline must not see a write or a delivery; a flush landing
  // on the FILL cycle itself still cancels the miss delivery.
  assign bus.icache_addr  = bus.pc_in;
  assign bus.icache_we    = icacheWe_q && bus.rdy;
  assign bus.icache_waddr = icacheWaddr_q;
  assign bus.icache_wdata = icacheWdata_q;
  assign bus.mem_req      = memReq_q;
  assign bus.mem_addr     = memAddr_q;
  assign bus.inst_valid   = instValid_q && bus.rdy && !((state_q == FILL) && bus.flush);
  assign bus.inst_out     = instOut_q;
  assign bus.inst_pc      = instPc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: directed fetches push expected deliveries
// and refills into queues, a negedge monitor pops and compares them.
module tb_ifetch_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic clk = 1'b0;
  logic rst;

  ifetch_ctrl_if #(.ADDR_W(32), .INST_W(32)) bus ();

  ifetch_ctrl #(.ADDR_W(32), .INST_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  xfer_t expInst[$];
  xfer_t expFill[$];
  xfer_t monInst, monFill;
  int    compared   = 0;
  int    mismatched = 0;

  logic [31:0] cTag [8];
  logic [31:0] cData[8];
  logic        cValid[8];
  int          cPtr = 0;

  // Small fully associative ICache model so refilled lines hit afterwards.
  always_comb begin
    bus.icache_hit  = 1'b0;
    bus.icache_inst = '0;
    for (int i = 0; i < 8; i++) begin
      if (cValid[i] && cTag[i] == bus.icache_addr) begin
        bus.icache_hit  = 1'b1;
        bus.icache_inst = cData[i];
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.icache_we) begin
      cTag[cPtr]   <= bus.icache_waddr;
      cData[cPtr]  <= bus.icache_wdata;
      cValid[cPtr] <= 1'b1;
      cPtr         <= (cPtr + 1) % 8;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic fetchReq, input logic [31:0] pc,
                               input logic queueFull, input logic flushIn);
    bus.fetch_req  = fetchReq;
    bus.pc_in      = pc;
    bus.queue_full = queueFull;
    bus.flush      = flushIn;
  endtask

  task automatic driveByte(input logic valid, input logic [7:0] b);
    bus.mem_byte_valid = valid;
    bus.mem_byte       = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every delivery and every refill must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.inst_valid) begin
        if (expInst.size() == 0) begin
          checkOutput("unexpected_inst_valid", 32'd1, 32'd0);
        end else begin
          monInst = expInst.pop_front();
          checkOutput("inst_pc", bus.inst_pc, monInst.addr);
          checkOutput("inst_out", bus.inst_out, monInst.data);
        end
      end
      if (bus.icache_we) begin
        if (expFill.size() == 0) begin
          checkOutput("unexpected_icache_we", 32'd1, 32'd0);
        end else begin
          monFill = expFill.pop_front();
          checkOutput("icache_waddr", bus.icache_waddr, monFill.addr);
          checkOutput("icache_wdata", bus.icache_wdata, monFill.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.rdy = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    bus.mem_grant = 1'b0;
    driveByte(1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cValid[i] = 1'b0;
      cTag[i]   = '0;
      cData[i]  = '0;
    end
    cTag[7]   = 32'h100;
    cData[7]  = 32'h00A00093;
    cValid[7] = 1'b1;

    #1 rst = 1'b1;
    #1;
    checkOutput("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("rst_inst_out", bus.inst_out, 32'd0);
    checkOutput("rst_inst_pc", bus.inst_pc, 32'd0);
    checkOutput("rst_icache_we", 32'(bus.icache_we), 32'd0);
    checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
    bus.pc_in = 32'h123;
    #1;
    checkOutput("icache_addr_comb", bus.icache_addr, 32'h123);
    step();
    rst = 1'b0;
    step();

    // Hit at 0x100
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    expInst.push_back('{32'h100, 32'h00A00093});
    step();
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0);
    sample();
    checkOutput("hit_valid", 32'(bus.inst_valid), 32'd1);
    checkOutput("hit_no_mem_req", 32'(bus.mem_req), 32'd0);

    // Miss at 0x200, grant after two REQ cycles, bytes back to back
    step();
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
    expInst.push_back('{32'h200, 32'h00100513});
    expFill.push_back('{32'h200, 32'h00100513});
    step();
    applyStimulus(1'b0, 32'h200, 1'b0, 1'b0);
    sample();
    checkOutput("miss_mem_req", 32'(bus.mem_req), 32'd1);
    checkOutput("miss_mem_addr", bus.mem_addr, 32'h200);
    checkOutput("miss_no_valid", 32'(bus.inst_valid), 32'd0);
    step();
    bus.mem_grant = 1'b1;
    sample();
    checkOutput("miss_mem_req_held", 32'(bus.mem_req), 32'd1);
    step();
    bus.mem_grant = 1'b0;
    driveByte(1'b1, 8'h13);
    sample();
    checkOutput("miss_mem_req_dropped", 32'(bus.mem_req), 32'd0);
    step(); driveByte(1'b1, 8'h05);
    step(); driveByte(1'b1, 8'h10);
    step(); driveByte(1'b1, 8'h00);
    step(); driveByte(1'b0, 8'h00);
    sample();
    checkOutput("miss_fill_we", 32'(bus.icache_we), 32'd1);
    checkOutput("miss_fill_valid", 32'(bus.inst_valid), 32'd1);
    step();
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
    expInst.push_back('{32'h200, 32'h00100513});
    step();
    applyStimulus(1'b0, 32'h200, 1'b0, 1'b0);
    sample();
    checkOutput("refetch_valid", 32'(bus.inst_valid), 32'd1);
    checkOutput("refetch_no_mem_req", 32'(bus.mem_req), 32'd0);

    // Flush while in REQ at 0x280
    step();
    applyStimulus(1'b1, 32'h280, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h280, 1'b0, 1'b1);
    sample();
    checkOutput("reqflush_mem_req_before", 32'(bus.mem_req), 32'd1);
    step();
    applyStimulus(1'b0, 32'h280, 1'b0, 1'b0);
    sample();
    checkOutput("reqflush_mem_req_drop", 32'(bus.mem_req), 32'd0);
    step();
    step();
    sample();
    checkOutput("reqflush_stays_idle", 32'(bus.mem_req), 32'd0);
    step();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    expInst.push_back('{32'h100, 32'h00A00093});
    step();
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0);
    sample();
    checkOutput("after_reqflush_hit", 32'(bus.inst_valid), 32'd1);

    // Flush after byte 1 of a miss at 0x300: refill but no delivery
    step();
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
    expFill.push_back('{32'h300, 32'h00300093});
    step();
    applyStimulus(1'b0, 32'h300, 1'b0, 1'b0);
    bus.mem_grant = 1'b1;
    step();
    bus.mem_grant = 1'b0;
    driveByte(1'b1, 8'h93);
    step(); driveByte(1'b1, 8'h00);
    step(); driveByte(1'b1, 8'h30); bus.flush = 1'b1;
    step(); driveByte(1'b1, 8'h00); bus.flush = 1'b0;
    step(); driveByte(1'b0, 8'h00);
    sample();
    checkOutput("abandon_fill_we", 32'(bus.icache_we), 32'd1);
    checkOutput("abandon_no_valid", 32'(bus.inst_valid), 32'd0);
    step();
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    expInst.push_back('{32'h100, 32'h00A00093});
    step();
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0);
    sample();
    checkOutput("post_abandon_accept", 32'(bus.inst_valid), 32'd1);

    // rdy stall mid-RECV at 0x400; junk bytes during the stall must be ignored
    step();
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0);
    expInst.push_back('{32'h400, 32'h01234537});
    expFill.push_back('{32'h400, 32'h01234537});
    step();
    applyStimulus(1'b0, 32'h400, 1'b0, 1'b0);
    bus.mem_grant = 1'b1;
    step();
    bus.mem_grant = 1'b0;
    driveByte(1'b1, 8'h37);
    step(); driveByte(1'b1, 8'h45);
    step(); driveByte(1'b1, 8'hEE); bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("stall_no_we", 32'(bus.icache_we), 32'd0);
      checkOutput("stall_no_valid", 32'(bus.inst_valid), 32'd0);
      checkOutput("stall_mem_req", 32'(bus.mem_req), 32'd0);
      step();
    end
    bus.rdy = 1'b1;
    driveByte(1'b1, 8'h23);
    step(); driveByte(1'b1, 8'h01);
    step(); driveByte(1'b0, 8'h00);
    sample();
    checkOutput("stall_fill_we", 32'(bus.icache_we), 32'd1);
    checkOutput("stall_fill_valid", 32'(bus.inst_valid), 32'd1);

    // Back-pressure and flush in IDLE block the accept
    step();
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      checkOutput("qfull_hit_no_valid", 32'(bus.inst_valid), 32'd0);
      step();
    end
    applyStimulus(1'b1, 32'h500, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      sample();
      checkOutput("qfull_miss_no_mem_req", 32'(bus.mem_req), 32'd0);
      step();
    end
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'h100, 1'b0, 1'b0);
    sample();
    checkOutput("idle_flush_no_valid", 32'(bus.inst_valid), 32'd0);

    // Asynchronous reset in the middle of RECV at 0x600
    step();
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h600, 1'b0, 1'b0);
    bus.mem_grant = 1'b1;
    step();
    bus.mem_grant = 1'b0;
    driveByte(1'b1, 8'h11);
    step(); driveByte(1'b1, 8'h22);
    step(); driveByte(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_inst_out", bus.inst_out, 32'd0);
    checkOutput("arst_inst_pc", bus.inst_pc, 32'd0);
    checkOutput("arst_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("arst_icache_we", 32'(bus.icache_we), 32'd0);
    checkOutput("arst_inst_valid", 32'(bus.inst_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h600, 1'b0, 1'b1);
    sample();
    checkOutput("arst_fetch_lost_mem_req", 32'(bus.mem_req), 32'd1);
    checkOutput("arst_fetch_lost_addr", bus.mem_addr, 32'h600);
    step();
    applyStimulus(1'b0, 32'h600, 1'b0, 1'b0);
    sample();
    checkOutput("arst_cleanup_mem_req", 32'(bus.mem_req), 32'd0);

    step();
    step();
    sample();
    checkOutput("inst_queue_drained", 32'(expInst.size()), 32'd0);
    checkOutput("fill_queue_drained", 32'(expFill.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller between the instruction queue and the direct-mapped ICache. It looks up the fetch PC in the ICache and returns the instruction on a hit. On a miss it requests the word from the byte-serial memory arbiter, assembles four bytes, refills the ICache and returns the instruction. It also handles queue-full back-pressure, branch flush and the global `rdy` stall.

## Interface
- `ADDR_W`, 32, fetch address width
- `INST_W`, 32, instruction width (always 4 bytes)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `rdy`  in  1  global enable; 0 freezes all state
- `fetch_req`  in  1  queue wants the instruction at `pc_in`
- `pc_in`  in  ADDR_W  fetch PC, stable while `fetch_req`=1
- `queue_full`  in  1  queue cannot accept an instruction
- `flush`  in  1  branch mispredict; cancel the in-flight fetch
- `icache_addr`  out  ADDR_W  lookup address, combinationally equal to `pc_in`
- `icache_hit`  in  1  combinational hit for `icache_addr`
- `icache_inst`  in  INST_W  hit data
- `icache_we`  out  1  refill strobe
- `icache_waddr`  out  ADDR_W  refill address
- `icache_wdata`  out  INST_W  refill data
- `mem_req`  out  1  memory read request
- `mem_addr`  out  ADDR_W  word address of the miss
- `mem_grant`  in  1  arbiter accepted the request (1-cycle pulse)
- `mem_byte_valid`  in  1  `mem_byte` holds the next byte
- `mem_byte`  in  8  returned byte, ascending address order
- `inst_valid`  out  1  one-cycle pulse, instruction delivered
- `inst_out`  out  INST_W  delivered instruction
- `inst_pc`  out  ADDR_W  PC of `inst_out`

## Operation
- States are IDLE, REQ, RECV and FILL.
- Accept condition: IDLE && `fetch_req` && !`queue_full` && !`flush` && !`inst_valid`.
- **IDLE**
  - On accept with `icache_hit`=1: register `inst_out`=`icache_inst` and `inst_pc`=`pc_in`; pulse `inst_valid` next cycle; stay in IDLE.
  - On accept with `icache_hit`=0: latch `pc_in` into `miss_pc` and go to REQ.
- **REQ**
  - Hold `mem_req`=1 and `mem_addr`=`miss_pc` until `mem_grant`.
  - On `mem_grant`: deassert `mem_req`, clear the byte counter, go to RECV.
- **RECV**
  - Each `mem_byte_valid` writes `mem_byte` into bits [8k+7:8k] of the assembly register (little-endian), k = counter 0..3.
  - After byte 3 is captured, go to FILL.
- **FILL** (one cycle)
  - `icache_we`=1, `icache_waddr`=`miss_pc`, `icache_wdata`=assembled word.
  - Unless the fetch is abandoned: `inst_valid`=1, `inst_out`=assembled word, `inst_pc`=`miss_pc`.
  - Then go to IDLE.
- **Flush**
  - IDLE: no accept that cycle.
  - REQ: drop `mem_req` and go to IDLE; no memory traffic results.
  - RECV or FILL: the memory transfer cannot be aborted. Set `abandon`=1, finish receiving, and still refill the ICache (the data is correct for `miss_pc`). Suppress `inst_valid`. `abandon` clears on entry to IDLE.
  - A flush in the same cycle as a hit pulse does not cancel that pulse; the queue discards it.
- **`rdy`=0**
  - Freeze every register. Bytes arriving are not captured; the arbiter honours `rdy` too.
  - Force `icache_we`=0 and `inst_valid`=0.
  - `mem_req` and `mem_addr` hold their values.
- **Reset**: `rst` asynchronously forces IDLE. All outputs and registers go to 0: `inst_valid`, `inst_out`, `inst_pc`, `icache_we`, `mem_req`, `mem_addr`, counter, `abandon`, `miss_pc`. A reset mid-miss loses the fetch without refilling.

## Timing
- Hit: accept in cycle N, `inst_valid` in N+1. Hit throughput is one instruction per 2 cycles, because the queue advances the PC on `inst_valid`.
- Miss, grant in cycle G, bytes in G+1..G+4 with no gaps: FILL, `icache_we` and `inst_valid` all fall in G+5. The earliest next accept is G+6.
- Gaps in `mem_byte_valid` extend RECV cycle-for-cycle.
- `icache_addr` is purely combinational. All other outputs are registered.
- The ICache write lands at the FILL clock edge; a lookup of the same address in the following cycle hits.

## Structure
- The shared definitions header holds the state encoding, `DATA_WIDTH`, `ICacheIndexSize` and the byte-count width; it must not redefine ICache geometry.
- One sub-module, `ifetch_byte_asm`: 2-bit counter, 32-bit assembly register, and a `done` output on the fourth byte. It has `clr` and `en` inputs gated by `rdy`.
- The FSM, the output registers and the `abandon` flag live in `ifetch_ctrl`.

## Test plan
- Hit: preload the ICache, then `pc_in`=0x100 with `fetch_req`=1 and `icache_inst`=0x00A00093 → next cycle `inst_valid`=1, `inst_out`=0x00A00093, `inst_pc`=0x100; no `mem_req`.
- Miss: `pc_in`=0x200 with the ICache empty; grant after 2 cycles; bytes 0x13,0x05,0x10,0x00 → `icache_we` with `icache_waddr`=0x200 and `icache_wdata`=0x00100513, `inst_valid` in the same cycle. Re-fetching 0x200 then hits in 1 cycle.
- Flush during REQ → `mem_req` drops the next cycle, state returns to IDLE, no `icache_we` and no `inst_valid`.
- Flush after byte 1 of a miss at 0x300 → all 4 bytes consumed, `icache_we`=1 for 0x300, `inst_valid` stays 0. A new fetch is accepted the cycle after FILL.
- `rdy`=0 for 3 cycles mid-RECV with `mem_byte_valid` held off → counter and outputs frozen; the word assembles correctly afterwards.
- `queue_full`=1 with `fetch_req`=1 → no accept and no lookup effect. Async `rst` pulse mid-RECV → all outputs 0 immediately, IDLE, no refill.
